// File: rtl/dsp_mac_sequencer.sv
// Sequencer for one DSP48A1 slice: streams unsigned operand pairs into the
// slice, accumulates them in P, and returns the 48-bit dot product.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int LAT   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_RSTP,
  input  logic [47:0]      DSP_P,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RES_DATA,
  output logic             BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] term_cnt;
  logic [7:0]       drain_cnt;
  logic [47:0]      res_data;
  logic             in_ready_q;
  logic             busy_q;
  logic             res_valid_q;
  logic             fire;
  logic             last_term;

  // Operands reach the slice only on a real handshake, so bubbles multiply to 0.
  assign fire       = IN_VALID && in_ready_q && !RST;
  assign last_term  = fire && (term_cnt == len_q - LEN_W'(1));
  assign DSP_A      = fire ? IN_A : 18'd0;
  assign DSP_B      = fire ? IN_B : 18'd0;
  assign DSP_OPMODE = 8'h09;
  assign DSP_RSTP   = RST || (state == CLEAR);

  assign IN_READY  = in_ready_q;
  assign BUSY      = busy_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      len_q       <= '0;
      term_cnt    <= '0;
      drain_cnt   <= 8'd0;
      res_data    <= 48'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            len_q    <= LEN;
            term_cnt <= '0;
            busy_q   <= 1'b1;
            if (LEN == '0) begin
              res_data    <= 48'd0;
              res_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          in_ready_q <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (fire) begin
            term_cnt <= term_cnt + LEN_W'(1);
          end
          if (last_term) begin
            in_ready_q <= 1'b0;
            drain_cnt  <= 8'd1;
            state      <= DRAIN;
          end
        end
        // The final term needs LAT cycles through A1/B1, M and P before P is valid.
        DRAIN: begin
          if (drain_cnt == 8'(LAT)) begin
            res_data    <= DSP_P;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        DONE: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1, M, P and OPMODE registers, synchronous RSTP on P).
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 8;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_rstp;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
  logic             busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rstp_seen = 1'b0;

  logic [17:0] a1_q = '0;
  logic [17:0] b1_q = '0;
  logic [35:0] m_q = '0;
  logic [47:0] p_q = '0;
  logic [7:0]  opmode_q = '0;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .LAT(LAT)) dut (
    .CLK(clk), .RST(rst), .START(start), .LEN(len),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_B(in_b),
    .DSP_A(dsp_a), .DSP_B(dsp_b), .DSP_OPMODE(dsp_opmode), .DSP_RSTP(dsp_rstp),
    .DSP_P(dsp_p), .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_DATA(res_data), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Slice model: A1REG/B1REG, MREG, PREG, OPMODEREG, SYNC reset on P.
  always @(posedge clk) begin
    a1_q     <= dsp_a;
    b1_q     <= dsp_b;
    m_q      <= 36'(a1_q) * 36'(b1_q);
    opmode_q <= dsp_opmode;
    if (dsp_rstp) p_q <= 48'd0;
    else if (opmode_q == 8'h09) p_q <= p_q + {12'd0, m_q};
  end
  assign dsp_p = p_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dsp_rstp && !rst) rstp_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_run(input logic [LEN_W-1:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
  endtask

  task automatic wait_result(output bit ok);
    int k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = res_valid;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_data !== 48'd0) begin bad++; $display("[TB] FAIL reset_res_data got=%0d want=0", res_data); end
    total++; if (dsp_rstp !== 1'b1) begin bad++; $display("[TB] FAIL reset_rstp got=%b want=1", dsp_rstp); end
    total++; if (dsp_opmode !== 8'h09) begin bad++; $display("[TB] FAIL opmode got=%h want=09", dsp_opmode); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (dsp_rstp !== 1'b0) begin bad++; $display("[TB] FAIL idle_rstp got=%b want=0", dsp_rstp); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int entry;
    start_run(8'd3);
    total++; if (dsp_rstp !== 1'b1) begin bad++; $display("[TB] FAIL clear_rstp got=%b want=1", dsp_rstp); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL clear_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    entry = cyc;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL issue_in_ready got=%b want=1", in_ready); end
    send(18'd1, 18'd4);
    send(18'd2, 18'd5);
    send(18'd3, 18'd6);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL drain_in_ready got=%b want=0", in_ready); end
    wait_result(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_timeout got=0 want=1"); end
    total++; if (cyc - entry !== 3 + LAT) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=%0d", cyc - entry, 3 + LAT); end
    total++; if (res_data !== 48'd32) begin bad++; $display("[TB] FAIL b2b_data got=%0d want=32", res_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL done_busy got=%b want=1", busy); end
    ack();
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ack_valid got=%b want=0", res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ack_busy got=%b want=0", busy); end
  endtask

  task automatic test_gaps();
    bit ok;
    start_run(8'd4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send(18'd2, 18'd2);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL gap_in_ready term=%0d got=%b want=1", i, in_ready); end
          @(negedge clk);
        end
      end
    end
    wait_result(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL gap_timeout got=0 want=1"); end
    total++; if (res_data !== 48'd16) begin bad++; $display("[TB] FAIL gap_data got=%0d want=16", res_data); end
    ack();
  endtask

  task automatic test_len_zero();
    rstp_seen = 1'b0;
    start_run(8'd0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL len0_valid got=%b want=1", res_valid); end
    total++; if (res_data !== 48'd0) begin bad++; $display("[TB] FAIL len0_data got=%0d want=0", res_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL len0_busy got=%b want=1", busy); end
    ack();
    total++; if (rstp_seen !== 1'b0) begin bad++; $display("[TB] FAIL len0_rstp got=%b want=0", rstp_seen); end
  endtask

  task automatic test_max_and_hold();
    bit ok;
    logic [47:0] held;
    start_run(8'd2);
    send(18'd262143, 18'd262143);
    send(18'd262143, 18'd262143);
    wait_result(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL max_timeout got=0 want=1"); end
    total++; if (res_data !== 48'd137437904898) begin bad++; $display("[TB] FAIL max_data got=%0d want=137437904898", res_data); end
    held = 48'd137437904898;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (res_valid !== 1'b1 || res_data !== held) begin bad++; $display("[TB] FAIL hold cycle=%0d got=%b/%0d want=1/%0d", i, res_valid, res_data, held); end
    end
    ack();
    start_run(8'd1);
    send(18'd7, 18'd9);
    wait_result(ok);
    total++; if (!ok || res_data !== 48'd63) begin bad++; $display("[TB] FAIL second_run got=%0d want=63", res_data); end
    ack();
  endtask

  task automatic test_reset_midrun();
    bit ok;
    bit seen;
    start_run(8'd5);
    send(18'd1, 18'd1);
    send(18'd1, 18'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 18'd5;
    in_b = 18'd5;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    total++; if (res_data !== 48'd0) begin bad++; $display("[TB] FAIL rst_res_data got=%0d want=0", res_data); end
    total++; if (dsp_a !== 18'd0 || dsp_b !== 18'd0) begin bad++; $display("[TB] FAIL rst_dsp_ab got=%0d/%0d want=0/0", dsp_a, dsp_b); end
    total++; if (dsp_rstp !== 1'b1) begin bad++; $display("[TB] FAIL rst_rstp got=%b want=1", dsp_rstp); end
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_result got=%b want=0", seen); end
    start_run(8'd1);
    send(18'd3, 18'd3);
    wait_result(ok);
    total++; if (!ok || res_data !== 48'd9) begin bad++; $display("[TB] FAIL post_rst_run got=%0d want=9", res_data); end
    ack();
  endtask

  task automatic test_ignored_start();
    bit ok;
    start_run(8'd2);
    @(negedge clk);
    send(18'd5, 18'd6);
    start = 1'b1;
    len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL issue_start in_ready got=%b want=1", in_ready); end
    send(18'd7, 18'd8);
    start = 1'b1;
    len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_result(ok);
    total++; if (!ok || res_data !== 48'd86) begin bad++; $display("[TB] FAIL ignored_start_data got=%0d want=86", res_data); end
    res_ready = 1'b1;
    start = 1'b1;
    len = 8'd0;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_start busy/valid got=%b/%b want=0/0", busy, res_valid); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL ack_start_next busy/valid got=%b/%b want=0/0", busy, res_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_max_and_hold();
    test_reset_midrun();
    test_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Upstream controller for one DSP48A1 slice. It streams operand pairs into the slice, runs an unsigned dot product in the slice accumulator, and returns the 48-bit sum.

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the term count.
REQ-002 SHALL have parameter LAT, default 3, cycles from the last issue cycle to the cycle in which DSP_P is sampled.
REQ-003 SHALL have port CLK  input  1  single clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port START  input  1  begin a run; sampled only in IDLE.
REQ-006 SHALL have port LEN  input  LEN_W  number of terms, latched on accepted START.
REQ-007 SHALL have ports IN_VALID input 1, IN_READY output 1, IN_A input 18, IN_B input 18  operand stream.
REQ-008 SHALL have ports DSP_A output 18, DSP_B output 18, DSP_OPMODE output 8, DSP_RSTP output 1  drive to the slice.
REQ-009 SHALL have port DSP_P  input  48  slice P output.
REQ-010 SHALL have ports RES_VALID output 1, RES_READY input 1, RES_DATA output 48  result handshake.
REQ-011 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-012 SHALL target a slice configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", RSTTYPE="SYNC", with all CE inputs tied high.

Function
REQ-013 SHALL implement states IDLE, CLEAR, ISSUE, DRAIN, DONE.
REQ-014 SHALL drive DSP_OPMODE constant 8'h09 (X=M, Z=P, pre-adder off, post-adder add, no carry-in).
REQ-015 SHALL drive DSP_A=IN_A and DSP_B=IN_B combinationally in a cycle where IN_VALID&&IN_READY; otherwise it SHALL drive 0 on both, so that bubbles add 0.
REQ-016 IDLE: on START=1 it SHALL latch LEN; LEN=0 SHALL go to DONE with RES_DATA=0; LEN>0 SHALL go to CLEAR.
REQ-017 CLEAR: it SHALL assert DSP_RSTP for exactly one cycle, then go to ISSUE.
REQ-018 ISSUE: IN_READY SHALL be 1; each handshake SHALL increment the term counter; the cycle of the LEN-th handshake SHALL be the last issue cycle, after which the block goes to DRAIN.
REQ-019 IN_READY SHALL be 0 in every state except ISSUE; operands offered outside ISSUE SHALL NOT be consumed.
REQ-020 DRAIN: the block SHALL wait so that DSP_P is sampled into RES_DATA in the LAT-th cycle after the last issue cycle, then go to DONE.
REQ-021 DONE: RES_VALID SHALL be 1 and RES_DATA SHALL be held stable until RES_READY=1; that cycle SHALL return the block to IDLE.
REQ-022 A START in the same cycle as the RES_READY handshake SHALL be ignored; the next START is accepted in IDLE.
REQ-023 START SHALL be ignored in every state other than IDLE.
REQ-024 Arithmetic SHALL be unsigned; the sum SHALL wrap modulo 2^48 with no overflow flag, and CARRYOUT is unused.
REQ-025 Throughput SHALL be one term per cycle when IN_VALID is held high; IN_VALID gaps SHALL only stretch ISSUE.

Reset
REQ-026 When RST=1 it SHALL force IDLE, clear the term counter, and set RES_VALID=0, RES_DATA=0, IN_READY=0, BUSY=0, DSP_A=0, DSP_B=0.
REQ-027 DSP_RSTP SHALL be 1 while RST=1.
REQ-028 RST in any state mid-run SHALL abandon the run; no RES_VALID pulse SHALL follow.

Verification
REQ-029 The bench SHALL instantiate the slice per REQ-012 and cover these scenarios:
- LEN=3; A=1,2,3; B=4,5,6 back-to-back -> RES_DATA=32; RES_VALID rises 3+LAT cycles after ISSUE entry.
- LEN=4; A=B=2 with IN_VALID low for 2 cycles between terms -> RES_DATA=16; IN_READY high throughout ISSUE.
- LEN=0 -> DONE directly; RES_DATA=0; DSP_RSTP never pulsed outside reset.
- LEN=2; A=B=262143 -> RES_DATA=137437904898; RES_READY held low 5 cycles -> RES_VALID and RES_DATA stable; a second run LEN=1, A=7, B=9 -> 63, so no residue from the first run.
- RST asserted after 2 of LEN=5 terms -> all outputs at reset values next cycle; a following run LEN=1, A=3, B=3 -> 9.
- START pulsed during ISSUE and DRAIN -> ignored; the current result is unchanged.
